cpu_btn_pio_irq: RTL
====================

// Module: cpu_btn_pio_irq
// PURPOSE
//   Parametrised Avalon-MM input PIO for push-buttons/switches on the NIOS system bus; successor to the plain read-only button port.
//   Adds per-channel synchroniser, debounce, edge capture with write-1-to-clear, and a masked interrupt request to the CPU.
//   Sits between board pins (in_port) and the NIOS data master; one instance per button/switch group.
// PARAMETERS
//   WIDTH            3        number of input channels (1..32)
//   SYNC_STAGES      2        synchroniser flops per channel (>=2)
//   DEBOUNCE_CYCLES  500000   consecutive stable clk cycles before a level is accepted (>=1; 10 ms @ 50 MHz)
//   EDGE_MODE        0        0 = rising, 1 = falling, 2 = any edge of the debounced level sets edgecapture
// PORTS
//   clk        in   1      system clock; the only clock
//   reset      in   1      synchronous, active-high reset
//   address    in   2      Avalon word address
//   write      in   1      Avalon write strobe (one-cycle)
//   writedata  in   32     Avalon write data
//   readdata   out  32     Avalon read data, registered
//   in_port    in   WIDTH  raw asynchronous pin inputs
//   irq        out  1      interrupt request, level, active-high
// BEHAVIOUR
//   Register map:
//     0 = debounced data (RO)
//     1 = reserved (reads 0)
//     2 = irqmask (RW, WIDTH bits)
//     3 = edgecapture (R, W1C)
//   Unused upper bits read 0; writes to 0/1 are ignored.
//   Reset values, applied on the clk edge while reset=1:
//     readdata=0, irqmask=0, edgecapture=0, debounced level=0, debounce counters=0, sync flops=0, irq=0.
//   Reset mid-debounce discards the partial count; no edge is flagged during reset.
//   Synchroniser: in_port passes through SYNC_STAGES flops; the synced value changes SYNC_STAGES cycles after a pin change.
//   Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
//     - synced == level: counter <= 0.
//     - synced != level: counter increments. When it reaches DEBOUNCE_CYCLES-1 with synced still different, level <= synced on the next edge and counter <= 0.
//     - Net effect: level follows a pin change after SYNC_STAGES+DEBOUNCE_CYCLES cycles. Any shorter pulse is dropped.
//   Edge detect: compares level with its previous-cycle copy. A qualifying edge per EDGE_MODE sets edgecapture[i] on the next edge.
//   W1C: write to address 3 clears each edgecapture bit where writedata[i]=1.
//     If a set and a clear hit the same bit in the same cycle, the set wins (bit stays 1).
//   irqmask: a write to address 2 loads writedata[WIDTH-1:0].
//   irq = |(edgecapture & irqmask), driven from registers; it changes the cycle after edgecapture or irqmask changes.
//   Read path: readdata <= mux(address) every cycle (no read strobe), so read latency is 1 cycle.
//     Data reads return the level, not the raw pin. Reading has no side effects.
//   An input held at 1 through reset yields a level 0->1 transition after the debounce time. In modes 0/2 it sets edgecapture; drivers clear edgecapture at init.
// STRUCTURE
//   Shared package cpu_pio_pkg:
//     - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3
//     - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
//   Sub-module btn_debounce (one channel: sync chain + counter + level), instantiated WIDTH times via generate.
//   Top level holds the edge detect, register file, read mux and irq.
// TESTING (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, WIDTH=3 unless noted)
//   1. Hold reset 3 cycles, release -> reads of addr 0/1/2/3 all return 0, irq=0; writes to addr 0/1 leave reads at 0.
//   2. in_port=3'b001 held -> addr0 reads 0x1 from cycle 2+4 on; edgecapture=0x1; irq stays 0; write irqmask=0x1 -> irq=1 next cycle.
//   3. in_port[1] 3-cycle glitch (shorter than the debounce time) -> addr0 and edgecapture never change; irq stays 0.
//   4. edgecapture=0x5, write 0x1 to addr3 -> reads 0x4; bit2 edge in the same cycle as a clear of 0x4 -> bit2 stays 1.
//   5. Reset asserted when a channel's count is 2 -> level stays 0, count restarts from 0 after release; full 4-cycle stable input still needed.
//   6. WIDTH=8, EDGE_MODE=2: in_port[7] 0->1->0 with settled gaps -> edgecapture[7] set on each transition; W1C between them re-arms it.

Source files
------------

// File: rtl/cpu_pio_pkg.sv
// Shared constants for the button/switch input PIO: register addresses and edge-mode encodings.
package cpu_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // True when the debounced level moved in the direction selected by mode.
  function automatic logic edge_hit(input int unsigned mode, input logic cur, input logic prev);
    case (mode)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One input channel: synchroniser chain followed by a stable-count debouncer.
module btn_debounce #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign level  = level_q;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (synced == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = synced;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/cpu_btn_pio_irq.sv
// Avalon-MM input PIO: debounced data, irq mask and W1C edge capture with a masked level irq.
module cpu_btn_pio_irq
  import cpu_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] level, level_prev_q, hit;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d;
  logic             unused_wdata;

  // Upper write-data bits beyond WIDTH are ignored.
  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .pin  (in_port[i]),
      .level(level[i])
    );
    assign hit[i] = edge_hit(EDGE_MODE, level[i], level_prev_q[i]);
  end

  always_comb begin
    irqmask_d = irqmask_q;
    if (write && address == ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];

    edgecap_d = edgecap_q;
    if (write && address == ADDR_EDGECAP) edgecap_d = edgecap_d & ~writedata[WIDTH-1:0];
    // Applied after the clear so a same-cycle edge survives.
    edgecap_d = edgecap_d | hit;

    irq_d = |(edgecap_q & irqmask_q);

    rd_d = '0;
    unique case (address)
      ADDR_DATA:    rd_d = 32'(level);
      ADDR_IRQMASK: rd_d = 32'(irqmask_q);
      ADDR_EDGECAP: rd_d = 32'(edgecap_q);
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_prev_q <= '0;
      irqmask_q    <= '0;
      edgecap_q    <= '0;
      rd_q         <= '0;
      irq_q        <= 1'b0;
    end else begin
      level_prev_q <= level;
      irqmask_q    <= irqmask_d;
      edgecap_q    <= edgecap_d;
      rd_q         <= rd_d;
      irq_q        <= irq_d;
    end
  end

  assign readdata = rd_q;
  assign irq      = irq_q;

endmodule
